// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decode/forward/execute signal bundle for the ALU operand stage
// master: upstream driver (decode, forwarding stages, EX consumer) ; slave: the operand stage
interface alu_operand_stage_if;
  // decode side
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1_addr;
  logic [4:0]  dec_rs2_addr;
  logic [4:0]  dec_rd_addr;
  logic [31:0] dec_rs1_data;
  logic [31:0] dec_rs2_data;
  logic [31:0] dec_pc;
  logic [31:0] dec_imm;
  logic [2:0]  dec_op;
  logic        dec_a_sel;
  logic        dec_b_sel;
  logic        dec_reg_write;
  // forwarding sources
  logic        fwd_mem_en;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  // control and execute side
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [2:0]  operation;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [31:0] ex_store_data;
  logic [15:0] stall_count;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rs1_data, dec_rs2_data,
           dec_pc, dec_imm, dec_op, dec_a_sel, dec_b_sel, dec_reg_write,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
           flush, ex_ready,
    input  dec_ready, ex_valid, data_a, data_b, operation, ex_rd_addr, ex_reg_write,
           ex_store_data, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rs1_data, dec_rs2_data,
           dec_pc, dec_imm, dec_op, dec_a_sel, dec_b_sel, dec_reg_write,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
           flush, ex_ready,
    output dec_ready, ex_valid, data_a, data_b, operation, ex_rd_addr, ex_reg_write,
           ex_store_data, stall_count
  );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode-to-execute operand register with MEM/WB forwarding
// Ports: clk (rising edge), rst_n (async active-low), bus (alu_operand_stage_if.slave):
//   decode handshake + operands in, MEM/WB forwards in, flush/ex_ready in,
//   held ALU operands, destination, store data and stall counter out.
module alu_operand_stage (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_stage_if.slave bus
);
  logic        r_valid;
  logic [31:0] r_data_a;
  logic [31:0] r_data_b;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [31:0] r_store;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic        r_a_sel;
  logic        r_b_sel;
  logic [15:0] r_stall_count;

  logic        w_dec_ready;
  logic        w_take;
  logic        w_stall;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

  // x0 reads as zero and is never forwarded; MEM is newer than WB so it wins.
  function automatic logic [31:0] fwd_value(
    input logic [4:0]  rs,
    input logic [31:0] fallback,
    input logic        mem_en,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (rs == 5'd0)                     return 32'd0;
    else if (mem_en && (mem_rd == rs))  return mem_data;
    else if (wb_en && (wb_rd == rs))    return wb_data;
    else                                return fallback;
  endfunction

  assign w_dec_ready = !r_valid || bus.ex_ready;
  assign w_take      = bus.dec_valid && w_dec_ready;
  assign w_stall     = r_valid && !bus.ex_ready;

  assign w_fwd_rs1 = fwd_value(bus.dec_rs1_addr, bus.dec_rs1_data,
                               bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_data,
                               bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
  assign w_fwd_rs2 = fwd_value(bus.dec_rs2_addr, bus.dec_rs2_data,
                               bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_data,
                               bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_data_a      <= 32'd0;
      r_data_b      <= 32'd0;
      r_op          <= 3'd0;
      r_rd          <= 5'd0;
      r_reg_write   <= 1'b0;
      r_store       <= 32'd0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_a_sel       <= 1'b0;
      r_b_sel       <= 1'b0;
      r_stall_count <= 16'd0;
    end else begin
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;

      if (bus.flush) begin
        // data fields are left as-is; only the valid/write qualifiers die
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
      end else if (w_take) begin
        r_valid     <= 1'b1;
        r_data_a    <= bus.dec_a_sel ? bus.dec_pc : w_fwd_rs1;
        r_data_b    <= bus.dec_b_sel ? bus.dec_imm : w_fwd_rs2;
        r_op        <= bus.dec_op;
        r_rd        <= bus.dec_rd_addr;
        r_reg_write <= bus.dec_reg_write;
        r_store     <= w_fwd_rs2;
        r_rs1       <= bus.dec_rs1_addr;
        r_rs2       <= bus.dec_rs2_addr;
        r_a_sel     <= bus.dec_a_sel;
        r_b_sel     <= bus.dec_b_sel;
      end else if (bus.ex_ready) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
      end else if (r_valid) begin
        // stalled: pick up results that arrive after capture; a miss keeps the held value
        if (!r_a_sel)
          r_data_a <= fwd_value(r_rs1, r_data_a, bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
        if (!r_b_sel)
          r_data_b <= fwd_value(r_rs2, r_data_b, bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
        r_store <= fwd_value(r_rs2, r_store, bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_data,
                             bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
      end
    end
  end

  assign bus.dec_ready     = w_dec_ready;
  assign bus.ex_valid      = r_valid;
  assign bus.data_a        = r_data_a;
  assign bus.data_b        = r_data_b;
  assign bus.operation     = r_op;
  assign bus.ex_rd_addr    = r_rd;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_store_data = r_store;
  assign bus.stall_count   = r_stall_count;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized model-based bench for alu_operand_stage
module tb_alu_operand_stage;
  logic clk;
  logic rst_n;
  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit check_en = 1'b0;

  // reference state: what the held entry must contain
  bit        m_valid;
  bit [31:0] m_a, m_b, m_st;
  bit [2:0]  m_op;
  bit [4:0]  m_rd, m_rs1, m_rs2;
  bit        m_rw, m_asel, m_bsel;
  int        m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  function automatic bit [31:0] fwd(input bit [4:0] rs, input bit [31:0] fallback);
    if (rs == 0) return 0;
    if (bus.fwd_mem_en && bus.fwd_mem_rd == rs) return bus.fwd_mem_data;
    if (bus.fwd_wb_en && bus.fwd_wb_rd == rs) return bus.fwd_wb_data;
    return fallback;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_st = 0; m_op = 0; m_rd = 0;
    m_rs1 = 0; m_rs2 = 0; m_rw = 0; m_asel = 0; m_bsel = 0; m_stall = 0;
  endtask

  // Evaluate the inputs present now, wait for the edge, then commit the model.
  task automatic step();
    bit        n_valid, n_rw;
    bit [31:0] n_a, n_b, n_st;
    bit [2:0]  n_op;
    bit [4:0]  n_rd, n_rs1, n_rs2;
    bit        n_asel, n_bsel;
    int        n_stall;
    bit        accepted;
    n_valid = m_valid; n_rw = m_rw; n_a = m_a; n_b = m_b; n_st = m_st; n_op = m_op;
    n_rd = m_rd; n_rs1 = m_rs1; n_rs2 = m_rs2; n_asel = m_asel; n_bsel = m_bsel;
    n_stall = m_stall;
    if (m_valid && !bus.ex_ready && m_stall < 65535) n_stall = m_stall + 1;
    accepted = bus.dec_valid && (!m_valid || bus.ex_ready);
    if (bus.flush) begin
      n_valid = 0; n_rw = 0;
    end else if (accepted) begin
      n_valid = 1;
      n_a  = bus.dec_a_sel ? bus.dec_pc  : fwd(bus.dec_rs1_addr, bus.dec_rs1_data);
      n_b  = bus.dec_b_sel ? bus.dec_imm : fwd(bus.dec_rs2_addr, bus.dec_rs2_data);
      n_st = fwd(bus.dec_rs2_addr, bus.dec_rs2_data);
      n_op = bus.dec_op; n_rd = bus.dec_rd_addr; n_rw = bus.dec_reg_write;
      n_rs1 = bus.dec_rs1_addr; n_rs2 = bus.dec_rs2_addr;
      n_asel = bus.dec_a_sel; n_bsel = bus.dec_b_sel;
    end else if (bus.ex_ready) begin
      n_valid = 0; n_rw = 0;
    end else if (m_valid) begin
      if (!m_asel) n_a = fwd(m_rs1, m_a);
      if (!m_bsel) n_b = fwd(m_rs2, m_b);
      n_st = fwd(m_rs2, m_st);
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_rw = n_rw; m_a = n_a; m_b = n_b; m_st = n_st; m_op = n_op;
    m_rd = n_rd; m_rs1 = n_rs1; m_rs2 = n_rs2; m_asel = n_asel; m_bsel = n_bsel;
    m_stall = n_stall;
  endtask

  // single compare process against the model, mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk("dec_ready",     {31'd0, bus.dec_ready},    {31'd0, (!m_valid || bus.ex_ready)});
      chk("ex_valid",      {31'd0, bus.ex_valid},     {31'd0, m_valid});
      chk("data_a",        bus.data_a,                m_a);
      chk("data_b",        bus.data_b,                m_b);
      chk("operation",     {29'd0, bus.operation},    {29'd0, m_op});
      chk("ex_rd_addr",    {27'd0, bus.ex_rd_addr},   {27'd0, m_rd});
      chk("ex_reg_write",  {31'd0, bus.ex_reg_write}, {31'd0, m_rw});
      chk("ex_store_data", bus.ex_store_data,         m_st);
      chk("stall_count",   {16'd0, bus.stall_count},  m_stall[31:0]);
    end
  end

  task automatic clear_inputs();
    bus.dec_valid = 0; bus.dec_rs1_addr = 0; bus.dec_rs2_addr = 0; bus.dec_rd_addr = 0;
    bus.dec_rs1_data = 0; bus.dec_rs2_data = 0; bus.dec_pc = 0; bus.dec_imm = 0;
    bus.dec_op = 0; bus.dec_a_sel = 0; bus.dec_b_sel = 0; bus.dec_reg_write = 0;
    bus.fwd_mem_en = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 0;
    bus.fwd_wb_en = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0;
    bus.flush = 0; bus.ex_ready = 0;
  endtask

  task automatic randomize_inputs(input bit allow_ready);
    bus.dec_valid     = ($urandom_range(0, 3) != 0);
    bus.dec_rs1_addr  = 5'($urandom_range(0, 7));
    bus.dec_rs2_addr  = 5'($urandom_range(0, 7));
    bus.dec_rd_addr   = 5'($urandom);
    bus.dec_rs1_data  = $urandom;
    bus.dec_rs2_data  = $urandom;
    bus.dec_pc        = $urandom;
    bus.dec_imm       = $urandom;
    bus.dec_op        = 3'($urandom);
    bus.dec_a_sel     = ($urandom_range(0, 3) == 0);
    bus.dec_b_sel     = ($urandom_range(0, 3) == 0);
    bus.dec_reg_write = 1'($urandom);
    bus.fwd_mem_en    = 1'($urandom);
    bus.fwd_mem_rd    = 5'($urandom_range(0, 7));
    bus.fwd_mem_data  = $urandom;
    bus.fwd_wb_en     = 1'($urandom);
    bus.fwd_wb_rd     = 5'($urandom_range(0, 7));
    bus.fwd_wb_data   = $urandom;
    bus.flush         = allow_ready && ($urandom_range(0, 9) == 0);
    bus.ex_ready      = allow_ready && ($urandom_range(0, 9) < 6);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex_valid"},     {31'd0, bus.ex_valid},     32'd0);
    chk({tag, "_data_a"},       bus.data_a,                32'd0);
    chk({tag, "_data_b"},       bus.data_b,                32'd0);
    chk({tag, "_operation"},    {29'd0, bus.operation},    32'd0);
    chk({tag, "_rd"},           {27'd0, bus.ex_rd_addr},   32'd0);
    chk({tag, "_reg_write"},    {31'd0, bus.ex_reg_write}, 32'd0);
    chk({tag, "_store"},        bus.ex_store_data,         32'd0);
    chk({tag, "_stall_count"},  {16'd0, bus.stall_count},  32'd0);
    chk({tag, "_dec_ready"},    {31'd0, bus.dec_ready},    32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    check_en = 1'b1;

    // single capture then consume
    bus.dec_valid = 1; bus.dec_rs1_addr = 3; bus.dec_rs1_data = 5;
    bus.dec_rs2_addr = 4; bus.dec_rs2_data = 7; bus.dec_op = 3'd0; bus.ex_ready = 1;
    step();
    chk("cap_data_a", bus.data_a, 32'd5);
    chk("cap_data_b", bus.data_b, 32'd7);
    chk("cap_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.dec_valid = 0;
    step();
    chk("consume_valid", {31'd0, bus.ex_valid}, 32'd0);

    // forwarding priority and x0
    bus.dec_valid = 1; bus.dec_rs1_addr = 6; bus.dec_rs1_data = 1;
    bus.fwd_wb_en = 1; bus.fwd_wb_rd = 6; bus.fwd_wb_data = 2;
    bus.fwd_mem_en = 1; bus.fwd_mem_rd = 6; bus.fwd_mem_data = 3;
    step();
    chk("fwd_prio_a", bus.data_a, 32'd3);
    bus.dec_rs1_addr = 0;
    step();
    chk("fwd_x0_a", bus.data_a, 32'd0);

    // stall refresh
    clear_inputs(); bus.ex_ready = 1;
    step();
    bus.ex_ready = 0; bus.dec_valid = 1; bus.dec_rs2_addr = 9; bus.dec_rs2_data = 32'h10;
    step();
    chk("stall_cap_b", bus.data_b, 32'h10);
    bus.fwd_wb_en = 1; bus.fwd_wb_rd = 9; bus.fwd_wb_data = 32'hAB;
    bus.dec_rs2_addr = 1; bus.dec_rs2_data = 32'h77;
    #1 chk("stall_ready0", {31'd0, bus.dec_ready}, 32'd0);
    step();
    chk("stall_ref_b", bus.data_b, 32'hAB);
    chk("stall_ready1", {31'd0, bus.dec_ready}, 32'd0);
    bus.fwd_wb_en = 0;
    step();
    chk("stall_cnt2", {16'd0, bus.stall_count}, 32'd2);
    chk("stall_hold_b", bus.data_b, 32'hAB);

    // pc / immediate select with forwards present
    clear_inputs(); bus.ex_ready = 1;
    step();
    bus.dec_valid = 1; bus.dec_a_sel = 1; bus.dec_b_sel = 1;
    bus.dec_pc = 32'h100; bus.dec_imm = 32'hFFFF_FFFC;
    bus.dec_rs1_addr = 2; bus.dec_rs2_addr = 5; bus.dec_rs2_data = 32'h99;
    bus.fwd_wb_en = 1; bus.fwd_wb_rd = 2; bus.fwd_wb_data = 32'h22;
    bus.fwd_mem_en = 1; bus.fwd_mem_rd = 5; bus.fwd_mem_data = 32'h55;
    step();
    chk("sel_a_pc", bus.data_a, 32'h100);
    chk("sel_b_imm", bus.data_b, 32'hFFFF_FFFC);
    chk("sel_store", bus.ex_store_data, 32'h55);

    // flush with a simultaneous accepted decode item, then a normal capture
    clear_inputs();
    bus.ex_ready = 1; bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_rd_addr = 3; bus.flush = 1;
    step();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    bus.flush = 0; bus.dec_rd_addr = 7;
    step();
    chk("post_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("post_flush_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    chk("post_flush_rd", {27'd0, bus.ex_rd_addr}, 32'd7);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs(1'b1);
      step();
    end

    // saturation: make sure an entry is held, then stall for a long time
    clear_inputs(); bus.ex_ready = 1; bus.dec_valid = 1;
    step();
    for (int i = 0; i < 70000; i++) begin
      randomize_inputs(1'b0);
      step();
    end
    chk("sat_count", {16'd0, bus.stall_count}, 32'h0000_FFFF);
    chk("sat_valid", {31'd0, bus.ex_valid}, 32'd1);

    // asynchronous reset pulse mid-stall
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    #1 rst_n = 1'b1;
    clear_inputs(); bus.ex_ready = 1; bus.dec_valid = 1;
    bus.dec_rs1_addr = 1; bus.dec_rs1_data = 32'h1234;
    step();
    chk("after_rst_a", bus.data_a, 32'h1234);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
